check_progress_ctrl: RTL and testbench
======================================

Name: check_progress_ctrl

Overview:
- Verification-side controller that aggregates per-cycle check completions from N_SRC checker agents of the HCI testbench.
- Tracks total checks and errors against TOT_CHECK.
- Emits progress milestones (percent steps) one at a time over a valid/ready handshake.
- Sequences end of test (run, drain, done or timeout) with a single pass/fail verdict.

Parameters:
- N_SRC, 4, number of checker sources.
- TOT_CHECK, 1000, expected total checks (≥1).
- CNT_W, 32, counter width.
- N_STEPS, 10, milestone count. Must divide 100.
- TIMEOUT, 10000, max idle cycles between checks while running (0 = disabled).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- start_i  in  1  pulse: begin test (accepted only in IDLE)
- check_valid_i  in  N_SRC  per-source check completed this cycle
- check_err_i  in  N_SRC  per-source mismatch; qualified by check_valid_i
- n_checks_o  out  CNT_W  accumulated checks
- n_errors_o  out  CNT_W  accumulated errors
- ms_valid_o  out  1  milestone available
- ms_ready_i  in  1  milestone consumer ready
- ms_pct_o  out  7  milestone percent (k*100/N_STEPS)
- busy_o  out  1  state is RUN or DRAIN
- done_o  out  1  state is DONE or TMO (sticky)
- pass_o  out  1  valid when done_o
- timeout_o  out  1  state is TMO
- overflow_o  out  1  sticky: checks arrived after TOT_CHECK reached

Behaviour:
- Reset (async, rst_i=1): state IDLE. All counters 0. Milestone index k=1. Pending=0. All outputs 0.
- FSM states: IDLE, RUN, DRAIN, DONE, TMO.
  - IDLE→RUN: on start_i. Counters cleared the same edge.
  - RUN→DRAIN: when n_checks_o reaches ≥TOT_CHECK.
  - RUN→TMO: when idle counter == TIMEOUT.
  - DRAIN→DONE: when no milestone is pending and ms_valid_o is low.
  - DONE, TMO: terminal until reset. start_i ignored.
- Accumulation: in RUN only. n_checks += popcount(check_valid_i), n_errors += popcount(check_valid_i & check_err_i), both registered, 1-cycle latency. Inputs are ignored outside RUN, except that in DRAIN/DONE any valid sets overflow_o and counters do not change. Counters saturate at 2^CNT_W−1.
- Milestone detection: step k crossed when n_checks*N_STEPS ≥ k*TOT_CHECK. Comparison uses CNT_W+8 bit products with no division.
  - Multiple steps crossed in one cycle (burst): each is queued and emitted in ascending order, one per handshake.
  - Pending count ≤ N_STEPS.
- Milestone handshake:
  - ms_valid_o rises the cycle after the crossing is registered.
  - ms_pct_o is stable while ms_valid_o=1 and ms_ready_i=0.
  - Transfer on valid&ready. The next pending milestone is presented the following cycle, not combinationally.
  - A new crossing coinciding with a transfer is added to the pending count without loss.
  - Step N_STEPS (100) is always the last emitted.
- Idle timer: counts RUN cycles with check_valid_i==0. Cleared on any valid. Inactive in other states.
- Verdict: pass_o = (n_errors_o==0) && !overflow_o when entering DONE. pass_o is forced to 0 in TMO. overflow_o asserted after DONE clears pass_o next cycle.
- Reset mid-operation: immediate return to IDLE. A milestone handshake in progress is dropped.

Optional Feature:
- Macro: CHECK_PROGRESS_CTRL_ERR_STOP_EN.
- Defined: the first error in RUN moves the FSM to DONE in the next cycle with pass_o=0. Pending milestones are discarded and ms_valid_o deasserts in that cycle.
- Undefined: errors are only counted. The test runs to TOT_CHECK or timeout.

Test Plan:
- Basic run: TOT_CHECK=100, N_STEPS=10, start, one check/cycle on src0, ms_ready_i=1 → milestones 10,20,…,100 in order. done_o after 100 checks plus drain. pass_o=1. n_checks_o=100.
- Burst with backpressure: 4 sources all valid for 25 cycles, ms_ready_i=0 until cycle 30 → 10 milestones queued. ms_pct_o held at 10 while stalled, then one per handshake. DONE only after pct 100 is transferred.
- Errors: 100 checks with check_err_i on 3 of them → n_errors_o=3, pass_o=0, all 10 milestones emitted (macro undefined). With macro defined: DONE one cycle after the first error, ms_valid_o=0, pass_o=0.
- Timeout: TIMEOUT=50, 20 checks, then no valids → timeout_o=1 exactly 50 cycles after the last valid. done_o=1, pass_o=0.
- Overflow and terminal state: after DONE, pulse check_valid_i=4'b0011 → overflow_o=1, pass_o drops to 0, n_checks_o unchanged. start_i ignored.
- Async reset mid-RUN at 47 checks with ms_valid_o=1 → all outputs 0 immediately without a clock edge. A new start restarts from 0 with first milestone 10.

Source files
------------

// File: rtl/check_progress_ctrl_if.sv
// check_progress_ctrl_if: checker completion inputs and milestone valid/ready channel.
interface check_progress_ctrl_if #(parameter int N_SRC = 4);
    logic [N_SRC-1:0] check_valid_i;
    logic [N_SRC-1:0] check_err_i;
    logic             ms_valid_o;
    logic             ms_ready_i;
    logic [6:0]       ms_pct_o;
    modport master (output check_valid_i, check_err_i, ms_ready_i, input ms_valid_o, ms_pct_o);
    modport slave  (input check_valid_i, check_err_i, ms_ready_i, output ms_valid_o, ms_pct_o);
endinterface

// File: rtl/check_progress_ctrl.sv
// check_progress_ctrl: aggregates checker completions, emits percent milestones, sequences end of test.
// Optional CHECK_PROGRESS_CTRL_ERR_STOP_EN: the first error in RUN ends the test as failed.
module check_progress_ctrl #(
    parameter int N_SRC     = 4,
    parameter int TOT_CHECK = 1000,
    parameter int CNT_W     = 32,
    parameter int N_STEPS   = 10,
    parameter int TIMEOUT   = 10000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    check_progress_ctrl_if.slave bus,
    output logic [CNT_W-1:0]     n_checks_o,
    output logic [CNT_W-1:0]     n_errors_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic                 timeout_o,
    output logic                 overflow_o
);
    localparam int PW   = CNT_W + 8;
    localparam int SW   = $clog2(N_SRC + 1);
    localparam int KW   = $clog2(N_STEPS + 2);
    localparam int STEP = 100 / N_STEPS;
`ifdef CHECK_PROGRESS_CTRL_ERR_STOP_EN
    localparam bit ERR_STOP = 1'b1;
`else
    localparam bit ERR_STOP = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_TMO} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_n_checks, r_n_errors, r_idle;
    logic [CNT_W-1:0] w_idle_nxt, w_chk_nxt, w_err_nxt;
    logic [CNT_W:0]   w_chk_sum, w_err_sum;
    logic [SW-1:0]    w_nv, w_ne;
    logic [PW-1:0]    w_prod;
    logic [KW-1:0]    r_k, r_e, r_pend, w_hi, w_new, w_avail;
    logic [6:0]       r_ms_pct;
    logic             r_ms_valid, r_pass, r_ovf;
    logic             w_any, w_err_hit, w_xfer, w_load, w_stop;

    always_comb begin
        w_nv = '0;
        w_ne = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_nv = w_nv + SW'(bus.check_valid_i[i]);
            w_ne = w_ne + SW'(bus.check_valid_i[i] & bus.check_err_i[i]);
        end
    end

    assign w_any      = |bus.check_valid_i;
    assign w_err_hit  = |(bus.check_valid_i & bus.check_err_i);
    assign w_chk_sum  = {1'b0, r_n_checks} + (CNT_W+1)'(w_nv);
    assign w_err_sum  = {1'b0, r_n_errors} + (CNT_W+1)'(w_ne);
    assign w_chk_nxt  = w_chk_sum[CNT_W] ? '1 : w_chk_sum[CNT_W-1:0];
    assign w_err_nxt  = w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
    assign w_idle_nxt = r_idle + CNT_W'(1);
    assign w_prod     = PW'(r_n_checks) * PW'(N_STEPS);

    // number of steps whose threshold the registered count has reached
    always_comb begin
        w_hi = '0;
        for (int j = 1; j <= N_STEPS; j++)
            if (w_prod >= PW'(j) * PW'(TOT_CHECK)) w_hi = w_hi + KW'(1);
    end

    assign w_new   = ((r_state == S_RUN || r_state == S_DRAIN) && w_hi >= r_k) ? w_hi - r_k + KW'(1) : '0;
    assign w_avail = r_pend + w_new;
    assign w_xfer  = r_ms_valid & bus.ms_ready_i;
    assign w_load  = (!r_ms_valid || w_xfer) && w_avail != '0;
    assign w_stop  = ERR_STOP && r_state == S_RUN && w_err_hit;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = start_i ? S_RUN : S_IDLE;
            S_RUN:
                if (w_stop) w_state_nxt = S_DONE;
                else if (r_n_checks >= CNT_W'(TOT_CHECK)) w_state_nxt = S_DRAIN;
                else if (TIMEOUT != 0 && !w_any && w_idle_nxt == CNT_W'(TIMEOUT)) w_state_nxt = S_TMO;
            S_DRAIN: if (w_avail == '0 && !r_ms_valid) w_state_nxt = S_DONE;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_n_checks <= '0;
            r_n_errors <= '0;
            r_idle     <= '0;
            r_k        <= KW'(1);
            r_e        <= KW'(1);
            r_pend     <= '0;
            r_ms_valid <= 1'b0;
            r_ms_pct   <= '0;
            r_pass     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && start_i) begin
                r_n_checks <= '0;
                r_n_errors <= '0;
            end else if (r_state == S_RUN) begin
                r_n_checks <= w_chk_nxt;
                r_n_errors <= w_err_nxt;
            end
            r_idle <= (r_state == S_RUN && !w_any) ? w_idle_nxt : '0;
            if ((r_state == S_DRAIN || r_state == S_DONE) && w_any) r_ovf <= 1'b1;
            if (w_stop) begin
                r_pend     <= '0;
                r_ms_valid <= 1'b0;
            end else begin
                r_k    <= r_k + w_new;
                r_pend <= w_load ? w_avail - KW'(1) : w_avail;
                if (w_load) begin
                    r_ms_valid <= 1'b1;
                    r_ms_pct   <= 7'(int'(r_e) * STEP);
                    r_e        <= r_e + KW'(1);
                end else if (w_xfer) r_ms_valid <= 1'b0;
            end
            if (r_state == S_DRAIN && w_state_nxt == S_DONE) r_pass <= r_n_errors == '0 && !r_ovf;
            else if (r_ovf) r_pass <= 1'b0;
        end
    end

    assign n_checks_o   = r_n_checks;
    assign n_errors_o   = r_n_errors;
    assign bus.ms_valid_o = r_ms_valid;
    assign bus.ms_pct_o = r_ms_pct;
    assign busy_o       = r_state == S_RUN || r_state == S_DRAIN;
    assign done_o       = r_state == S_DONE || r_state == S_TMO;
    assign pass_o       = r_pass;
    assign timeout_o    = r_state == S_TMO;
    assign overflow_o   = r_ovf;
endmodule

// File: tb/tb_check_progress_ctrl.sv
// tb_check_progress_ctrl: directed and random runs against a queue-based model of the controller.
module tb_check_progress_ctrl;
    localparam int N_SRC = 4;
    localparam int TOT   = 100;
    localparam int CNT_W = 32;
    localparam int NS    = 10;
    localparam int TMO   = 50;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3, M_TMO = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic start_i = 1'b0;
    logic [CNT_W-1:0] n_checks_o, n_errors_o;
    logic busy_o, done_o, pass_o, timeout_o, overflow_o;
    int n_chk = 0;
    int n_err = 0;
    int got[$];
    int exp_pct[10] = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100};

    check_progress_ctrl_if #(.N_SRC(N_SRC)) bus();

    check_progress_ctrl #(.N_SRC(N_SRC), .TOT_CHECK(TOT), .CNT_W(CNT_W), .N_STEPS(NS), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .bus(bus),
        .n_checks_o(n_checks_o), .n_errors_o(n_errors_o), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .timeout_o(timeout_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: milestones as a queue of percent values, thresholds by integer division
    int m_st = M_IDLE;
    longint m_chk = 0, m_err = 0;
    int m_idle = 0, m_det = 0, m_pct = 0;
    bit m_ovf = 0, m_pass = 0, m_valid = 0;
    int m_q[$];

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_st = M_IDLE; m_chk = 0; m_err = 0; m_idle = 0; m_det = 0; m_pct = 0;
            m_ovf = 0; m_pass = 0; m_valid = 0; m_q.delete();
        end else begin : step
            int nv, ne, ns, tgt;
            bit xfer, stop;
            nv = $countones(bus.check_valid_i);
            ne = $countones(bus.check_valid_i & bus.check_err_i);
            xfer = m_valid && bus.ms_ready_i;
            if (m_st == M_RUN || m_st == M_DRAIN) begin
                tgt = int'(m_chk * NS / TOT);
                if (tgt > NS) tgt = NS;
                while (m_det < tgt) begin
                    m_det++;
                    m_q.push_back(m_det * 100 / NS);
                end
            end
            stop = 0;
`ifdef CHECK_PROGRESS_CTRL_ERR_STOP_EN
            stop = (m_st == M_RUN) && ne > 0;
`endif
            ns = m_st;
            if (m_st == M_IDLE && start_i) ns = M_RUN;
            else if (m_st == M_RUN) ns = stop ? M_DONE : (m_chk >= TOT) ? M_DRAIN : (nv == 0 && m_idle + 1 == TMO) ? M_TMO : M_RUN;
            else if (m_st == M_DRAIN && m_q.size() == 0 && !m_valid) ns = M_DONE;
            if (m_st == M_DRAIN && ns == M_DONE) m_pass = (m_err == 0) && !m_ovf;
            else if (m_ovf) m_pass = 0;
            if (stop) begin
                m_q.delete();
                m_valid = 0;
            end else begin
                if (xfer) m_valid = 0;
                if (!m_valid && m_q.size() > 0) begin
                    m_pct = m_q.pop_front();
                    m_valid = 1;
                end
            end
            if (m_st == M_IDLE && start_i) begin
                m_chk = 0;
                m_err = 0;
            end else if (m_st == M_RUN) begin
                m_chk = m_chk + nv;
                m_err = m_err + ne;
                if (m_chk > 64'hFFFF_FFFF) m_chk = 64'hFFFF_FFFF;
                if (m_err > 64'hFFFF_FFFF) m_err = 64'hFFFF_FFFF;
            end
            m_idle = (m_st == M_RUN && nv == 0) ? m_idle + 1 : 0;
            if ((m_st == M_DRAIN || m_st == M_DONE) && nv > 0) m_ovf = 1;
            m_st = ns;
        end
    end

    always @(negedge clk_i) begin
        if (!rst_i) begin
            check("n_checks", n_checks_o, 32'(m_chk));
            check("n_errors", n_errors_o, 32'(m_err));
            check("ms_valid", 32'(bus.ms_valid_o), 32'(m_valid));
            if (m_valid) check("ms_pct", 32'(bus.ms_pct_o), 32'(m_pct));
            check("busy", 32'(busy_o), 32'(m_st == M_RUN || m_st == M_DRAIN));
            check("done", 32'(done_o), 32'(m_st == M_DONE || m_st == M_TMO));
            check("pass", 32'(pass_o), 32'(m_pass));
            check("timeout", 32'(timeout_o), 32'(m_st == M_TMO));
            check("overflow", 32'(overflow_o), 32'(m_ovf));
            if (bus.ms_valid_o && bus.ms_ready_i) got.push_back(int'(bus.ms_pct_o));
        end
    end

    task automatic drive(input logic [3:0] v, input logic [3:0] e, input logic r, input logic s);
        @(posedge clk_i);
        #1;
        bus.check_valid_i = v;
        bus.check_err_i = e;
        bus.ms_ready_i = r;
        start_i = s;
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        bus.check_valid_i = '0;
        bus.check_err_i = '0;
        bus.ms_ready_i = 1'b0;
        start_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        got.delete();
    endtask

    task automatic wait_done(input int budget, input logic r);
        int c = 0;
        while (!done_o && c < budget) begin
            drive(4'd0, 4'd0, r, 1'b0);
            c++;
        end
        check("done_reached", 32'(done_o), 32'd1);
    endtask

    task automatic check_list(input string name);
        check({name, "_count"}, 32'(got.size()), 32'd10);
        for (int i = 0; i < 10 && i < got.size(); i++) check(name, 32'(got[i]), 32'(exp_pct[i]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.check_valid_i = '0;
        bus.check_err_i = '0;
        bus.ms_ready_i = 1'b0;
        #12;
        check("rst_n_checks", n_checks_o, 32'd0);
        check("rst_ms_valid", 32'(bus.ms_valid_o), 32'd0);
        check("rst_busy_done", 32'({busy_o, done_o, pass_o, timeout_o, overflow_o}), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        drive(4'd0, 4'd0, 1'b1, 1'b1);
        repeat (100) drive(4'd1, 4'd0, 1'b1, 1'b0);
        wait_done(50, 1'b1);
        check("basic_n_checks", n_checks_o, 32'd100);
        check("basic_pass", 32'(pass_o), 32'd1);
        check_list("basic_ms");

        drive(4'b0011, 4'd0, 1'b1, 1'b1);
        drive(4'd0, 4'd0, 1'b1, 1'b1);
        check("ovf_set", 32'(overflow_o), 32'd1);
        check("ovf_n_checks", n_checks_o, 32'd100);
        drive(4'd0, 4'd0, 1'b1, 1'b0);
        check("ovf_pass_drop", 32'(pass_o), 32'd0);
        check("ovf_terminal", 32'({busy_o, done_o}), 32'd1);

        do_reset();
        drive(4'd0, 4'd0, 1'b0, 1'b1);
        repeat (25) drive(4'hF, 4'd0, 1'b0, 1'b0);
        repeat (4) drive(4'd0, 4'd0, 1'b0, 1'b0);
        check("burst_stall_valid", 32'(bus.ms_valid_o), 32'd1);
        check("burst_stall_pct", 32'(bus.ms_pct_o), 32'd10);
        check("burst_stall_done", 32'(done_o), 32'd0);
        wait_done(100, 1'b1);
        check("burst_n_checks", n_checks_o, 32'd100);
        check_list("burst_ms");

        do_reset();
        drive(4'd0, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 100; i++) begin
            drive(4'd1, {3'd0, i == 10 || i == 50 || i == 90}, 1'b1, 1'b0);
`ifdef CHECK_PROGRESS_CTRL_ERR_STOP_EN
            if (i == 11) begin
                check("errstop_done", 32'(done_o), 32'd1);
                check("errstop_ms_valid", 32'(bus.ms_valid_o), 32'd0);
                check("errstop_pass", 32'(pass_o), 32'd0);
                break;
            end
`endif
        end
`ifndef CHECK_PROGRESS_CTRL_ERR_STOP_EN
        wait_done(50, 1'b1);
        check("err_n_errors", n_errors_o, 32'd3);
        check("err_pass", 32'(pass_o), 32'd0);
        check_list("err_ms");
`endif

        do_reset();
        drive(4'd0, 4'd0, 1'b1, 1'b1);
        repeat (20) drive(4'd1, 4'd0, 1'b1, 1'b0);
        drive(4'd0, 4'd0, 1'b1, 1'b0);
        begin
            int c = 0;
            while (!timeout_o && c < 100) begin
                drive(4'd0, 4'd0, 1'b1, 1'b0);
                c++;
            end
            check("tmo_cycles", 32'(c), 32'd50);
        end
        check("tmo_done_pass", 32'({done_o, pass_o}), 32'd2);
        check("tmo_ms_count", 32'(got.size()), 32'd2);

        do_reset();
        drive(4'd0, 4'd0, 1'b0, 1'b1);
        repeat (47) drive(4'd1, 4'd0, 1'b0, 1'b0);
        drive(4'd0, 4'd0, 1'b0, 1'b0);
        check("pre_rst_n_checks", n_checks_o, 32'd47);
        check("pre_rst_ms_valid", 32'(bus.ms_valid_o), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_counts", n_checks_o | n_errors_o, 32'd0);
        check("async_rst_flags", 32'({bus.ms_valid_o, busy_o, done_o, pass_o, timeout_o, overflow_o}), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        got.delete();
        drive(4'd0, 4'd0, 1'b1, 1'b1);
        repeat (10) drive(4'd1, 4'd0, 1'b1, 1'b0);
        repeat (3) drive(4'd0, 4'd0, 1'b1, 1'b0);
        check("restart_first_ms", 32'(got.size() > 0 ? got[0] : -1), 32'd10);

        for (int r = 0; r < 8; r++) begin
            int stopat, c, post;
            do_reset();
            drive(4'd0, 4'd0, 1'b1, 1'b1);
            stopat = (r % 3 == 2) ? int'($urandom_range(5, 30)) : 1000;
            c = 0;
            post = 0;
            while (c < 800 && post < 6) begin
                drive((c < stopat) ? 4'($urandom) : 4'd0, 4'($urandom) & 4'($urandom) & 4'($urandom),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 20) == 0);
                c++;
                if (done_o) post++;
            end
            check("rand_done", 32'(done_o), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
